// File: rtl/result_streamer.sv
// Two-slot result buffer that drains each {n, result} pair as a framed beat stream:
// one header beat carrying n, then the result split into BEAT_W chunks, LSB chunk first.
module result_streamer #(
    parameter int RES_W  = 128,
    parameter int BEAT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              done,
    input  logic [RES_W-1:0]  res_in,
    input  logic [4:0]        n_in,
    output logic              full,
    output logic              drop_err,
    output logic [BEAT_W-1:0] dout,
    output logic              dout_valid,
    output logic              dout_last,
    input  logic              dout_ready,
    output logic [15:0]       frame_cnt
);

    localparam int NBEATS = RES_W / BEAT_W;
    localparam int BCW    = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [BCW-1:0] BLAST = BCW'(NBEATS - 1);

    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

    state_t             state_q, state_d;
    logic [BCW-1:0]     bcnt_q, bcnt_d;
    logic               wptr_q, wptr_d;
    logic               rptr_q, rptr_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [RES_W-1:0]   slot_res_q [2];
    logic [RES_W-1:0]   slot_res_d [2];
    logic [4:0]         slot_n_q [2];
    logic [4:0]         slot_n_d [2];
    logic               full_q, full_d;
    logic               drop_q, drop_d;
    logic [BEAT_W-1:0]  dout_q, dout_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;
    logic [15:0]        fcnt_q, fcnt_d;

    logic               hs;
    logic               last_hs;
    logic               accept;
    logic [4:0]         hdr_n;
    logic [BEAT_W-1:0]  chunk [NBEATS];

    // The slot being drained is never written while occupied, so its chunks are stable.
    genvar gi;
    generate
        for (gi = 0; gi < NBEATS; gi++) begin : g_chunk
            assign chunk[gi] = slot_res_q[rptr_q][gi*BEAT_W +: BEAT_W];
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        bcnt_d     = bcnt_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        slot_res_d = slot_res_q;
        slot_n_d   = slot_n_q;
        fcnt_d     = fcnt_q;
        dout_d     = '0;

        hs      = valid_q & dout_ready;
        last_hs = (state_q == DATA) && hs && (bcnt_q == BLAST);
        // A slot freed by the final-beat handshake is reusable in the same cycle.
        accept  = done && ((cnt_q != 2'd2) || last_hs);

        if (accept) begin
            slot_res_d[wptr_q] = res_in;
            slot_n_d[wptr_q]   = n_in;
            wptr_d             = ~wptr_q;
        end
        if (last_hs) begin
            rptr_d = ~rptr_q;
            fcnt_d = fcnt_q + 16'd1;
        end
        cnt_d  = cnt_q + {1'b0, accept} - {1'b0, last_hs};
        full_d = (cnt_d == 2'd2);
        drop_d = drop_q | (done & ~accept);

        case (state_q)
            IDLE: begin
                if (cnt_q != 2'd0) state_d = HDR;
            end
            HDR: begin
                if (hs) begin
                    state_d = DATA;
                    bcnt_d  = '0;
                end
            end
            DATA: begin
                if (hs) begin
                    if (bcnt_q == BLAST) begin
                        state_d = (cnt_d != 2'd0) ? HDR : IDLE;
                        bcnt_d  = '0;
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Next header may come from the slot being written this very cycle.
        hdr_n = (accept && (wptr_q == rptr_d)) ? n_in : slot_n_q[rptr_d];

        valid_d = (state_d != IDLE);
        last_d  = (state_d == DATA) && (bcnt_d == BLAST);
        if (state_d == HDR) begin
            dout_d = {{(BEAT_W-5){1'b0}}, hdr_n};
        end else if (state_d == DATA) begin
            dout_d = chunk[bcnt_d];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            bcnt_q  <= '0;
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            cnt_q   <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                slot_res_q[i] <= '0;
                slot_n_q[i]   <= '0;
            end
            full_q  <= 1'b0;
            drop_q  <= 1'b0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            fcnt_q  <= 16'd0;
        end else begin
            state_q    <= state_d;
            bcnt_q     <= bcnt_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
            slot_res_q <= slot_res_d;
            slot_n_q   <= slot_n_d;
            full_q     <= full_d;
            drop_q     <= drop_d;
            dout_q     <= dout_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            fcnt_q     <= fcnt_d;
        end
    end

    assign full       = full_q;
    assign drop_err   = drop_q;
    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign dout_last  = last_q;
    assign frame_cnt  = fcnt_q;

endmodule

// File: doc/result_streamer.md
Name: result_streamer

Overview:
- Downstream stage of the recursive-evaluation datapath; consumes its 128-bit result plus the N that produced it.
- Captures each result into a 2-entry frame buffer, so the controller can start the next N while the previous result drains.
- Drains each result as a framed beat stream with a valid/ready handshake to the host interface.
- Reports buffer-full backpressure and dropped results to the controller.

Parameters:
- RES_W, 128: result width; must be an integer multiple of BEAT_W.
- BEAT_W, 16: output beat width; must be at least 8.
- NBEATS, RES_W/BEAT_W (default 8): data beats per frame. Derived; not overridable.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- done  in  1  one-cycle pulse from the controller: res_in and n_in are valid this cycle
- res_in  in  RES_W  result value (datapath out_)
- n_in  in  5  N that produced the result
- full  out  1  both buffer slots occupied; controller must not pulse done
- drop_err  out  1  sticky: a done pulse arrived while full
- dout  out  BEAT_W  stream data
- dout_valid  out  1  dout holds a beat
- dout_last  out  1  marks the final beat of a frame
- dout_ready  in  1  sink accepts the beat
- frame_cnt  out  16  count of frames fully transferred; wraps

Behaviour:
- Reset (rst=0, asynchronous):
  - Clears both slots, read/write pointers, beat counter, drop_err and frame_cnt.
  - Drives dout=0, dout_valid=0, dout_last=0, full=0.
  - A frame in progress is discarded with no partial completion.
- Storage:
  - 2-slot FIFO of {n, result}.
  - Write pointer wptr and read pointer rptr are 1-bit each; occupancy count cnt is 0..2.
  - full = (cnt==2), registered.
- Capture: on a clk edge with done=1 and a slot free, write {n_in, res_in} to slot[wptr], toggle wptr, and increment cnt.
- Frame format, in transmission order:
  - Header beat: n in bits [4:0], zero in all other bits.
  - Then NBEATS data beats, least-significant chunk first. Data beat k carries result[k*BEAT_W +: BEAT_W].
  - dout_last=1 only on data beat NBEATS-1.
- Output state machine:
  - States: IDLE, HDR, DATA. A beat counter bcnt (width clog2(NBEATS)) tracks data beats.
  - IDLE:
    - dout_valid=0.
    - If cnt>0, go to HDR next cycle.
    - Latency: done at edge t, from IDLE with empty buffer, gives a header beat valid after edge t+1.
  - HDR:
    - dout_valid=1, dout=header.
    - On dout_valid&dout_ready, go to DATA with bcnt=0.
  - DATA:
    - dout_valid=1, dout=data chunk bcnt.
    - On a handshake with bcnt<NBEATS-1, increment bcnt.
    - On a handshake with bcnt==NBEATS-1:
      - free slot[rptr], toggle rptr, decrement cnt, increment frame_cnt (modulo 2^16);
      - go to HDR if one more frame remains buffered, else go to IDLE.
    - Back-to-back frames have no idle cycle between them.
- Handshake rules:
  - dout, dout_valid and dout_last are registered.
  - While dout_valid=1 and dout_ready=0, dout and dout_last hold stable.
  - dout_valid never drops without a completed handshake.
  - dout_ready is ignored while dout_valid=0.
- Simultaneous events:
  - done together with the final-beat handshake while cnt==2: capture is accepted, because the slot frees in the same cycle. cnt stays 2 and full stays 1.
  - done together with the final-beat handshake while cnt==1: capture is accepted, cnt stays 1, and the state machine goes straight to HDR.
  - done while full and no slot frees that cycle: the result is dropped, drop_err is set to 1 and held until reset, and the slots are unchanged.
- Values are transferred unmodified: no arithmetic on the result. Header zero padding is exact.

Test Plan:
- Reset, then a single frame:
  - Stimulus: done with n_in=5 and res_in=128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF; dout_ready=1 throughout.
  - Required response:
    - header 16'h0005 is valid on the cycle after the done edge;
    - data beats follow in order: EEFF, CCDD, AABB, 8899, 6677, 4455, 2233, 0011;
    - dout_last=1 only on 0011;
    - frame_cnt goes to 1.
- Backpressure:
  - Stimulus: same frame, with dout_ready toggled as 1,0,0,1,0,1…
  - Required response: every beat is held stable while ready=0; no beat is lost or duplicated; the beat order is unchanged.
- Double buffering and overflow:
  - Stimulus: with dout_ready=0, pulse done three times (n=1,2,3).
  - Required response:
    - full=1 after the 2nd capture;
    - the 3rd pulse sets drop_err=1;
    - after dout_ready is raised, frames n=1 and n=2 stream back-to-back with no gap; n=3 never appears.
- Simultaneous capture and free:
  - Stimulus: with cnt==2, pulse done (n=9) on the same cycle as the final-beat handshake.
  - Required response: no drop_err; the n=9 frame streams after the remaining buffered frame.
- Asynchronous reset mid-frame:
  - Stimulus: assert rst=0 between clock edges during data beat 3.
  - Required response:
    - outputs go to 0 immediately, without waiting for a clock edge;
    - after release, the next done produces a complete, fresh frame;
    - frame_cnt restarts from 0.
- frame_cnt wrap:
  - Stimulus: force or stream 65536 frames.
  - Required response: frame_cnt returns to 0 with no effect on the data stream.
